retospect_lif_core: RTL and testbench

Leaky integrate-and-fire compute core for one neuron tile of the neurochip fabric. It sits directly downstream of the per-tile configuration shift register and the clockbox. It consumes the configured weights, threshold and decay-select value, and selects one decay tick from the shared clockbus. Each run cycle it integrates four input spike lines into a membrane potential and emits a one-cycle output spike when the threshold is reached, followed by a fixed refractory period.

---
 rtl/retospect_lif_core.sv | 137 +++++++++++++
 tb/tb_retospect_lif_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/retospect_lif_core.sv
// Leaky integrate-and-fire core for one neuron tile: integrates four weighted
// spike lines into a membrane potential, fires at threshold, then goes refractory.
module retospect_lif_core #(
    parameter int WEIGHT_W = 3,
    parameter int POT_W    = 6,
    parameter int REFRACT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reset_nn,
    input  logic                run_en,
    input  logic [WEIGHT_W-1:0] w1,
    input  logic [WEIGHT_W-1:0] w2,
    input  logic [WEIGHT_W-1:0] w3,
    input  logic [WEIGHT_W-1:0] w4,
    input  logic [3:0]          u_t,
    input  logic [2:0]          decay_sel,
    input  logic [7:0]          clockbus,
    input  logic [3:0]          spike_in,
    output logic                spike_out,
    output logic [POT_W-1:0]    potential,
    output logic                refractory,
    output logic [7:0]          spike_count
);

    typedef enum logic {INTEGRATE = 1'b0, REFRACTORY = 1'b1} state_t;

    localparam int              SUM_W     = POT_W + 2;
    localparam logic [3:0]      REFRACT_C = 4'(REFRACT);
    localparam logic [POT_W-1:0] POT_MAX  = {POT_W{1'b1}};

    function automatic logic signed [SUM_W-1:0] sext_w(input logic [WEIGHT_W-1:0] w);
        return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    endfunction

    state_t             state_r, state_nxt_s;
    logic [3:0]         rcnt_r, rcnt_nxt_s;
    logic [POT_W-1:0]   pot_r, pot_nxt_s;
    logic               spike_r, spike_nxt_s;
    logic [7:0]         cnt_r, cnt_nxt_s;

    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] raw_s;
    logic [POT_W-1:0]        clamp_s;
    logic                    dec_s;
    logic                    fire_s;

    // Weighted spike sum, leak, saturating clamp and threshold test.
    always_comb begin
        dec_s = clockbus[decay_sel];
        sum_s = (spike_in[0] ? sext_w(w1) : {SUM_W{1'b0}})
              + (spike_in[1] ? sext_w(w2) : {SUM_W{1'b0}})
              + (spike_in[2] ? sext_w(w3) : {SUM_W{1'b0}})
              + (spike_in[3] ? sext_w(w4) : {SUM_W{1'b0}});
        raw_s = $signed({2'b00, pot_r}) - $signed({{(SUM_W-1){1'b0}}, dec_s}) + sum_s;
        if (raw_s[SUM_W-1]) begin
            clamp_s = {POT_W{1'b0}};
        end else if (raw_s > $signed({2'b00, POT_MAX})) begin
            clamp_s = POT_MAX;
        end else begin
            clamp_s = raw_s[POT_W-1:0];
        end
        fire_s = (clamp_s >= {{(POT_W-4){1'b0}}, u_t});
    end

    // Next-state logic: network reset, freeze, integrate or count down refractory.
    always_comb begin
        state_nxt_s = state_r;
        rcnt_nxt_s  = rcnt_r;
        pot_nxt_s   = pot_r;
        cnt_nxt_s   = cnt_r;
        spike_nxt_s = 1'b0;
        if (reset_nn) begin
            state_nxt_s = INTEGRATE;
            rcnt_nxt_s  = 4'd0;
            pot_nxt_s   = {POT_W{1'b0}};
            cnt_nxt_s   = 8'd0;
        end else if (!run_en) begin
            spike_nxt_s = 1'b0;
        end else begin
            case (state_r)
                INTEGRATE: begin
                    if (fire_s) begin
                        pot_nxt_s   = {POT_W{1'b0}};
                        spike_nxt_s = 1'b1;
                        cnt_nxt_s   = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
                        if (REFRACT_C != 4'd0) begin
                            state_nxt_s = REFRACTORY;
                            rcnt_nxt_s  = REFRACT_C;
                        end else begin
                            state_nxt_s = INTEGRATE;
                        end
                    end else begin
                        pot_nxt_s = clamp_s;
                    end
                end
                REFRACTORY: begin
                    pot_nxt_s  = {POT_W{1'b0}};
                    rcnt_nxt_s = rcnt_r - 4'd1;
                    if (rcnt_r == 4'd1) begin
                        state_nxt_s = INTEGRATE;
                    end else begin
                        state_nxt_s = REFRACTORY;
                    end
                end
                default: begin
                    state_nxt_s = INTEGRATE;
                    rcnt_nxt_s  = 4'd0;
                    pot_nxt_s   = {POT_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= INTEGRATE;
            rcnt_r  <= 4'd0;
            pot_r   <= {POT_W{1'b0}};
            spike_r <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
            pot_r   <= pot_nxt_s;
            spike_r <= spike_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign spike_out   = spike_r;
    assign potential   = pot_r;
    assign refractory  = (state_r == REFRACTORY);
    assign spike_count = cnt_r;

endmodule

// File: tb/tb_retospect_lif_core.sv
// Directed bench for retospect_lif_core: a reference model pushes expected
// outputs to a queue at each step; they are popped and checked after the edge.
module tb_retospect_lif_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       reset_nn = 1'b0;
    logic       run_en = 1'b1;
    logic [2:0] w1 = 3'd0, w2 = 3'd0, w3 = 3'd0, w4 = 3'd0;
    logic [3:0] u_t = 4'd15;
    logic [2:0] decay_sel = 3'd0;
    logic [7:0] clockbus = 8'b0000_0010;
    logic [3:0] spike_in = 4'd0;

    logic       spike_out, refractory, spike0, refr0;
    logic [5:0] potential, pot0;
    logic [7:0] spike_count, cnt0;

    retospect_lif_core #(.WEIGHT_W(3), .POT_W(6), .REFRACT(2)) dut (
        .clk(clk), .rst_n(rst_n), .reset_nn(reset_nn), .run_en(run_en),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4), .u_t(u_t), .decay_sel(decay_sel),
        .clockbus(clockbus), .spike_in(spike_in), .spike_out(spike_out),
        .potential(potential), .refractory(refractory), .spike_count(spike_count)
    );

    retospect_lif_core #(.WEIGHT_W(3), .POT_W(6), .REFRACT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .reset_nn(reset_nn), .run_en(run_en),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4), .u_t(u_t), .decay_sel(decay_sel),
        .clockbus(clockbus), .spike_in(spike_in), .spike_out(spike0),
        .potential(pot0), .refractory(refr0), .spike_count(cnt0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       spk;
        logic [5:0] pot;
        logic       refr;
        logic [7:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    int pass_cnt = 0, fail_cnt = 0, total = 0;
    int m_pot = 0, m_st = 0, m_rc = 0, m_cnt = 0, m_spk = 0;
    localparam int M_R = 2;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int wval(input logic [2:0] w);
        return w[2] ? int'(w) - 8 : int'(w);
    endfunction

    task automatic model_reset();
        m_pot = 0; m_st = 0; m_rc = 0; m_cnt = 0; m_spk = 0;
    endtask

    task automatic model_edge();
        int s, nx;
        if (reset_nn) begin
            model_reset();
        end else if (!run_en) begin
            m_spk = 0;
        end else if (m_st == 0) begin
            s = 0;
            if (spike_in[0]) s += wval(w1);
            if (spike_in[1]) s += wval(w2);
            if (spike_in[2]) s += wval(w3);
            if (spike_in[3]) s += wval(w4);
            nx = m_pot - int'(clockbus[decay_sel]) + s;
            if (nx < 0) nx = 0;
            if (nx > 63) nx = 63;
            if (nx >= int'(u_t)) begin
                m_pot = 0; m_spk = 1;
                if (m_cnt < 255) m_cnt++;
                if (M_R > 0) begin m_st = 1; m_rc = M_R; end
            end else begin
                m_pot = nx; m_spk = 0;
            end
        end else begin
            m_spk = 0; m_pot = 0;
            if (m_rc == 1) m_st = 0;
            m_rc--;
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        model_edge();
        e.spk = m_spk[0]; e.pot = m_pot[5:0]; e.refr = m_st[0]; e.cnt = m_cnt[7:0];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".spike_out"},   {7'd0, spike_out},  {7'd0, e.spk});
        check({tag, ".potential"},   {2'd0, potential},  {2'd0, e.pot});
        check({tag, ".refractory"},  {7'd0, refractory}, {7'd0, e.refr});
        check({tag, ".spike_count"}, spike_count,        e.cnt);
    endtask

    task automatic nn_reset();
        reset_nn = 1'b1;
        step("nn_reset");
        reset_nn = 1'b0;
    endtask

    int leak_exp[8] = '{2, 3, 4, 3, 2, 1, 0, 0};

    initial begin
        // Power-on asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("por.spike_count", spike_count, 8'd0);
        check("por.potential", {2'd0, potential}, 8'd0);
        check("por.refractory", {7'd0, refractory}, 8'd0);
        #4 rst_n = 1'b1;

        // Single fire followed by exactly two refractory cycles.
        w1 = 3'd3; w2 = 3'd3; u_t = 4'd5; decay_sel = 3'd0;
        spike_in = 4'b0011; step("fire");
        check("fire.spike", {7'd0, spike_out}, 8'd1);
        spike_in = 4'b0011; step("refr1");
        check("refr1.refractory", {7'd0, refractory}, 8'd1);
        step("refr2");
        check("refr2.refractory", {7'd0, refractory}, 8'd0);
        spike_in = 4'b0001; step("post_fire");
        check("post_fire.pot", {2'd0, potential}, 8'd3);

        // Leak with floor at zero.
        nn_reset();
        u_t = 4'd15; w1 = 3'd2; w2 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            decay_sel = (i == 0) ? 3'd0 : 3'd1;
            spike_in  = (i < 3) ? 4'b0001 : 4'b0000;
            step("leak");
            check($sformatf("leak%0d.pot", i), {2'd0, potential}, 8'(leak_exp[i]));
        end

        // Negative weights and clamp at zero.
        nn_reset();
        decay_sel = 3'd0; w1 = 3'd3; w2 = 3'b100;
        spike_in = 4'b0001; step("neg_a");
        spike_in = 4'b0001; step("neg_b");
        spike_in = 4'b0011; step("neg_c");
        check("neg_c.pot", {2'd0, potential}, 8'd5);
        spike_in = 4'b0010; step("neg_d");
        check("neg_d.pot", {2'd0, potential}, 8'd1);
        spike_in = 4'b0010; step("neg_clamp");
        check("neg_clamp.pot", {2'd0, potential}, 8'd0);

        // Decay gated by a sparse clockbus tick.
        nn_reset();
        w1 = 3'd2; w2 = 3'd0; spike_in = 4'b0001;
        step("tick_ld"); step("tick_ld");
        spike_in = 4'b0000; decay_sel = 3'd3;
        for (int i = 0; i < 8; i++) begin
            clockbus[3] = (i % 4 == 0);
            step("tick");
        end
        clockbus[3] = 1'b0;
        check("tick.pot", {2'd0, potential}, 8'd2);

        // Freeze while integrating, then while refractory.
        run_en = 1'b0; spike_in = 4'b0001;
        for (int i = 0; i < 3; i++) step("freeze_int");
        check("freeze_int.pot", {2'd0, potential}, 8'd2);
        run_en = 1'b1; decay_sel = 3'd0; w1 = 3'd3; w2 = 3'd3; u_t = 4'd5;
        spike_in = 4'b0011; step("freeze_fire");
        run_en = 1'b0;
        for (int i = 0; i < 3; i++) step("freeze_refr");
        check("freeze_refr.refractory", {7'd0, refractory}, 8'd1);
        run_en = 1'b1;
        step("resume1"); step("resume2"); step("resume3");

        // Network reset in the middle of refractory.
        spike_in = 4'b0011; step("mid_fire");
        step("mid_refr");
        nn_reset();
        check("nn_mid.refractory", {7'd0, refractory}, 8'd0);

        // Asynchronous reset between edges with non-zero state.
        spike_in = 4'b0011; step("async_fire");
        rst_n = 1'b0;
        #2;
        model_reset();
        check("async.spike_out", {7'd0, spike_out}, 8'd0);
        check("async.refractory", {7'd0, refractory}, 8'd0);
        check("async.spike_count", spike_count, 8'd0);
        #2 rst_n = 1'b1;

        // Always-fire and count saturation.
        nn_reset();
        u_t = 4'd0; spike_in = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            step("sat");
            check($sformatf("sat%0d.spike0", i), {7'd0, spike0}, 8'd1);
            if (i == 99) check("sat99.cnt0", cnt0, 8'd100);
        end
        check("sat.cnt0", cnt0, 8'd255);
        check("sat.refr0", {7'd0, refr0}, 8'd0);
        check("sat.pot0", {2'd0, pot0}, 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
